// File: rtl/fifo_ring_if.sv
// Producer/consumer bundle for fifo_ring: request and data signals plus
// registered status outputs.
interface fifo_ring_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             circular;
  logic             flush;
  logic             write;
  logic [WIDTH-1:0] datain;
  logic             read;
  logic             clear_flags;
  logic [WIDTH-1:0] dataout;
  logic             valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output circular, flush, write, datain, read, clear_flags,
    input  dataout, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  circular, flush, write, datain, read, clear_flags,
    output dataout, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ring.sv
// Synchronous FIFO with replay (circular) mode, threshold flags, flush and
// sticky overflow/underflow flags. All outputs are registered or decoded from count.
module fifo_ring #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic         clk,
  input logic         reset,
  fifo_ring_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dataout_q;
  logic             valid_q, overflow_q, underflow_q;

  logic             rd_ok, wr_ok, wr_rej, rd_rej, rotate, mem_we;
  logic [WIDTH-1:0] mem_wdata;

  always_comb begin
    rd_ok  = bus.read && (count_q != '0);
    rd_rej = bus.read && !rd_ok;
    wr_ok  = 1'b0;
    wr_rej = 1'b0;
    rotate = 1'b0;
    // In replay mode a read owns the tail slot, so a concurrent write is dropped.
    if (bus.circular && rd_ok) begin
      rotate = 1'b1;
      wr_rej = bus.write;
    end else if (bus.write) begin
      if ((count_q != DEPTH_C) || rd_ok) wr_ok  = 1'b1;
      else                               wr_rej = 1'b1;
    end

    count_d = count_q;
    if (wr_ok && !rd_ok)                 count_d = count_q + CW'(1);
    else if (rd_ok && !wr_ok && !rotate) count_d = count_q - CW'(1);

    mem_we    = wr_ok || rotate;
    mem_wdata = rotate ? mem[rd_ptr] : bus.datain;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      dataout_q   <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + AW'(1);
        dataout_q <= mem[rd_ptr];
      end
      if (mem_we) wr_ptr <= wr_ptr + AW'(1);
      count_q     <= count_d;
      valid_q     <= rd_ok;
      // A new error in the same cycle as clear_flags wins.
      overflow_q  <= (overflow_q  && !bus.clear_flags) || wr_rej;
      underflow_q <= (underflow_q && !bus.clear_flags) || rd_rej;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && !bus.flush && mem_we) mem[wr_ptr] <= mem_wdata;
  end

  assign bus.dataout      = dataout_q;
  assign bus.valid        = valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ring.sv
// Bench for fifo_ring: directed vector table, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_fifo_ring;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_ring_if #(.WIDTH(W), .DEPTH(D)) bus ();
  fifo_ring #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  logic         m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    bit rst_n, fl, ci, wr, rd, cl;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    bit vld;
    int cnt;
    bit ovf, unf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit rd_ok, wr_ok, wr_rej;
    if (!reset) begin
      mq.delete(); m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
    end else if (bus.flush) begin
      mq.delete(); m_valid = 0;
    end else begin
      rd_ok  = bus.read && (mq.size() > 0);
      wr_rej = 0;
      if (bus.circular && rd_ok) begin
        m_dout = mq.pop_front();
        mq.push_back(m_dout);
        wr_rej = bus.write;
      end else begin
        wr_ok  = bus.write && ((mq.size() < D) || rd_ok);
        wr_rej = bus.write && !wr_ok;
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(bus.datain);
      end
      m_valid = rd_ok;
      m_ovf = (m_ovf && !bus.clear_flags) || wr_rej;
      m_unf = (m_unf && !bus.clear_flags) || (bus.read && !rd_ok);
    end
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("m_dout",  bus.dataout, m_dout);
    chk("m_valid", bus.valid, m_valid);
    chk("m_count", bus.count, n);
    chk("m_empty", bus.empty, n == 0);
    chk("m_full",  bus.full, n == D);
    chk("m_afull", bus.almost_full, n >= D - 1);
    chk("m_aempty", bus.almost_empty, n <= 1);
    chk("m_ovf",   bus.overflow, m_ovf);
    chk("m_unf",   bus.underflow, m_unf);
  endtask

  task automatic cyc(input bit rst_n, fl, ci, wr, rd, cl, input logic [W-1:0] din);
    reset           = rst_n;
    bus.flush       = fl;
    bus.circular    = ci;
    bus.write       = wr;
    bus.read        = rd;
    bus.clear_flags = cl;
    bus.datain      = din;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  function automatic void add(input bit rst_n, fl, ci, wr, rd, cl, input logic [W-1:0] din,
                              input logic [W-1:0] dout, input bit vld, input int cnt,
                              input bit ovf, unf);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.ci = ci; v.wr = wr; v.rd = rd; v.cl = cl; v.din = din;
    v.dout = dout; v.vld = vld; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [W-1:0] rep[7];
    rep = '{32'hA, 32'hE, 32'h47F, 32'hA, 32'hE, 32'h47F, 32'hA};

    bus.circular = 0; bus.flush = 0; bus.write = 0; bus.read = 0;
    bus.clear_flags = 0; bus.datain = '0;

    //   rst fl ci wr rd cl din      dout vld cnt ovf unf
    add(0, 0, 0, 0, 0, 0, 0,        0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        0,  0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 1, 0, 0, i, 0, 0, i, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 0, 1, 0, 0, i, 1, 4 - i, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 1, 0, 0, 10 + i, 4, 0, i, 0, 0);
    add(1, 0, 0, 1, 0, 0, 15,       4,  0, 4, 1, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 0, 1, 0, 0, 10 + i, 1, 4 - i, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0,        14, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 0,        14, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 1, 0, 0, i, 14, 0, i, 0, 0);
    add(1, 0, 0, 1, 1, 0, 9,        1,  1, 4, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,        2,  1, 3, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,        3,  1, 2, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,        4,  1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,        9,  1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 7,        9,  0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0,        7,  1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0,        7,  0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst_n, tbl[i].fl, tbl[i].ci, tbl[i].wr, tbl[i].rd, tbl[i].cl, tbl[i].din);
      chk($sformatf("v%0d_dout", i),  bus.dataout,   tbl[i].dout);
      chk($sformatf("v%0d_valid", i), bus.valid,     tbl[i].vld);
      chk($sformatf("v%0d_count", i), bus.count,     tbl[i].cnt);
      chk($sformatf("v%0d_ovf", i),   bus.overflow,  tbl[i].ovf);
      chk($sformatf("v%0d_unf", i),   bus.underflow, tbl[i].unf);
    end

    // circular replay, then read+write in replay drops the write
    cyc(1, 0, 0, 1, 0, 0, 32'hA);
    cyc(1, 0, 0, 1, 0, 0, 32'hE);
    cyc(1, 0, 0, 1, 0, 0, 32'h47F);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 1, 0, 1, 0, 0);
      chk($sformatf("rep%0d_dout", i), bus.dataout, rep[i]);
      chk($sformatf("rep%0d_count", i), bus.count, 3);
    end
    cyc(1, 0, 1, 1, 1, 0, 0);
    chk("rep_rw_ovf", bus.overflow, 1);
    chk("rep_rw_count", bus.count, 3);
    chk("rep_rw_dout", bus.dataout, 32'hE);

    // flush with read+write in the same cycle; sticky overflow survives
    cyc(1, 1, 0, 1, 1, 0, 5);
    chk("flush_count", bus.count, 0);
    chk("flush_valid", bus.valid, 0);
    chk("flush_ovf", bus.overflow, 1);
    cyc(1, 0, 0, 0, 0, 1, 0);
    chk("clr_ovf", bus.overflow, 0);

    // mode toggle preserves stored order
    cyc(1, 0, 0, 1, 0, 0, 32'hA);
    cyc(1, 0, 0, 1, 0, 0, 32'hE);
    cyc(1, 0, 0, 1, 0, 0, 32'h47F);
    cyc(1, 0, 1, 0, 1, 0, 0);
    chk("tog_rot", bus.dataout, 32'hA);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("tog_d0", bus.dataout, 32'hE);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("tog_d1", bus.dataout, 32'h47F);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("tog_d2", bus.dataout, 32'hA);
    chk("tog_empty", bus.empty, 1);

    // reset mid-stream with overflow set
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 0, 32'h100 + i);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_dout", bus.dataout, 32'h100);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("rst_dout", bus.dataout, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_aempty", bus.almost_empty, 1);

    // random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 150) != 0, ($urandom % 40) == 0, ($urandom % 3) == 0,
          $urandom % 2, $urandom % 2, ($urandom % 12) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_ring.md
# fifo_ring

Parametrised synchronous FIFO, the successor to the fixed-width fifo. It adds configurable width and depth, a circular (replay) mode that rotates stored entries instead of consuming them, occupancy and threshold flags, flush, and sticky error flags. It sits between a producer and a consumer in the same clock domain. Typical use is buffering a stream and replaying a short stored sequence on demand.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 4: number of entries; power of two, at least 2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; state clears on a clk edge with reset=0.
- circular  in  1  1 = replay mode: a read rotates the head entry to the tail.
- flush  in  1  synchronous empty request.
- write  in  1  write request.
- datain  in  WIDTH  write data.
- read  in  1  read request.
- dataout  out  WIDTH  registered read data.
- valid  out  1  dataout carries data from a read accepted in the previous cycle.
- full, empty  out  1 each  occupancy flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.
- clear_flags  in  1  clears overflow and underflow.

## Operation
- Storage is a DEPTH x WIDTH array addressed by rd_ptr and wr_ptr, each $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH. count is held as a separate register.
- Priority on each edge, highest first: reset=0, then flush, then read/write.
- **Reset:**
  - dataout=0, valid=0, count=0, empty=1, full=0.
  - almost_empty=1, almost_full=0 (for AF_LEVEL>0).
  - overflow=0, underflow=0, both pointers 0.
  - Memory contents are not cleared.
- **Flush:** pointers and count go to 0 and valid goes to 0. Sticky flags are unchanged, and any read or write in the same cycle is ignored.
- **Normal mode (circular=0):**
  - A read is accepted iff count>0: it pops the head and loads dataout.
  - A write is accepted iff count<DEPTH, or a read is accepted in the same cycle.
  - Read+write when full: both accepted, count unchanged.
  - Read+write when empty: write accepted, read rejected.
- **Circular mode (circular=1):**
  - A read is accepted iff count>0. The head is output on dataout and also written to wr_ptr; both pointers advance and count is unchanged.
  - count=1 replays the same word every cycle.
  - A write without a read behaves as in normal mode.
  - Read+write in the same cycle: the read rotates and the write is dropped, setting overflow.
- **Errors:**
  - A rejected write sets overflow; a rejected read sets underflow.
  - Both flags stay set until clear_flags=1 or reset. If clear_flags and a new error occur in the same cycle, the flag stays set.
- **Flags:** empty=(count==0), full=(count==DEPTH), almost_full and almost_empty are all decoded from registered count. There is no combinational path from any input to any output.
- circular is sampled every cycle and may toggle between any two reads. Stored order is preserved across mode changes.

## Timing
- Write latency: data is readable on the cycle after the write edge. count/empty/full update one edge after the accepted operation.
- Read latency is 1. dataout and valid register on the accepting edge.
  - valid=0 on cycles following no read or a rejected read.
  - dataout holds its last value when valid=0.
- Back-to-back reads stream one word per cycle. Back-to-back writes accept one word per cycle until full.
- A reset or flush asserted mid-stream takes effect on that edge, and valid is 0 on the following cycle.

## Test plan
- **Reset, then fill.** DEPTH=4, WIDTH=32: write 1,2,3,4 on consecutive cycles -> count 1..4, full=1 after the 4th edge, almost_full=1 at count 3. Then read 4 times -> dataout 1,2,3,4 with valid=1, empty=1 at the end, no sticky flags.
- **Boundary errors.**
  - Write 5 values with no read -> 5th rejected, overflow=1, count=4.
  - Read 5 times -> 5th rejected, underflow=1, valid=0 on that following cycle.
  - clear_flags -> both flags return to 0.
- **Simultaneous read+write.**
  - When full (1,2,3,4) with datain=9 -> dataout=1, count stays 4. Drain -> 2,3,4,9.
  - When empty with datain=7 -> read rejected, underflow=1, count=1.
- **Circular replay.** Write 0xA, 0xE, 0x47F, set circular=1, read 7 cycles -> dataout 0xA,0xE,0x47F,0xA,0xE,0x47F,0xA, count stays 3. Then a write of 0 with read high -> write dropped, overflow=1.
- **Mode toggle.** With 0xA, 0xE, 0x47F stored: circular=1, read once (0xA rotates) -> circular=0, drain -> 0xE, 0x47F, 0xA, then empty.
- **Flush and reset mid-operation.**
  - Flush with count=3 plus read+write in the same cycle -> count=0, valid=0, sticky flags unchanged.
  - Later, reset=0 during streaming reads -> all outputs reach reset values on the next cycle.
